seq_divider: RTL and testbench

- Sequential unsigned restoring divider; the inverse datapath to the team's add/subtract multiplier.
- Produces one quotient bit per clock using a (WIDTH+1)-bit trial subtraction.
- Controlled by a Start/Done handshake that matches the lab multiplier's Run/release style.
- Sits beside the multiplier in the arithmetic lab top level and is driven from switches or a host FSM.

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Brief    : Sequential unsigned restoring divider. Produces one quotient bit
//             per clock using a (WIDTH+1)-bit trial subtraction. It is driven
//             by a Start/Done handshake, and divide-by-zero is reported.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_divzero;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_divzero_nxt;

    // Upper half of {R,Q} after a one-bit left shift, and the trial difference.
    // R is always below 2^(WIDTH-1) before the last shift, so the bit shifted
    // out of R is zero and the WIDTH+1 bit subtraction cannot overflow.
    logic [WIDTH-1:0] w_upper;
    logic [WIDTH:0]   w_trial;

    assign w_upper = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_trial = {1'b0, w_upper} - {1'b0, r_div};

    // State register; reset drops any partially computed result at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; every variable defaults to hold.
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_quo_nxt     = r_quo;
        w_div_nxt     = r_div;
        w_cnt_nxt     = r_cnt;
        w_divzero_nxt = r_divzero;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (Divisor != '0) begin
                        w_rem_nxt     = '0;
                        w_quo_nxt     = Dividend;
                        w_div_nxt     = Divisor;
                        w_cnt_nxt     = '0;
                        w_divzero_nxt = 1'b0;
                        w_state_nxt   = S_CALC;
                    end else begin
                        w_rem_nxt     = Dividend;
                        w_quo_nxt     = '1;
                        w_divzero_nxt = 1'b1;
                        w_state_nxt   = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (!w_trial[WIDTH]) begin
                    w_rem_nxt = w_trial[WIDTH-1:0];
                    w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem_nxt = w_upper;
                    w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Holding Start keeps us here so a held request runs only once.
                if (!Start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: partial remainder, quotient, divisor, step count.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_divzero <= 1'b0;
        end else begin
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_div     <= w_div_nxt;
            r_cnt     <= w_cnt_nxt;
            r_divzero <= w_divzero_nxt;
        end
    end

    assign Quotient  = r_quo;
    assign Remainder = r_rem;
    assign Busy      = (r_state == S_CALC);
    assign Done      = (r_state == S_DONE);
    assign DivZero   = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Brief    : Self-checking bench for seq_divider, using directed and random
//             divisions that are compared against an arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             Clk;
    logic             Reset_n;
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(WIDTH)) u_dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one division. The load edge counts as edge 1. If scramble is set,
    // the operands change after the third edge. hold is the number of extra
    // cycles that Start stays high once Done is seen.
    task automatic run_div(input string tag, input logic [WIDTH-1:0] dd,
                           input logic [WIDTH-1:0] dv, input bit scramble,
                           input int hold);
        int edges;
        int busy_cnt;
        bit stable;
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        int exp_lat;
        if (dv == 0) begin
            exp_q   = '1;
            exp_r   = dd;
            exp_lat = 1;
        end else begin
            exp_q   = WIDTH'(int'(dd) / int'(dv));
            exp_r   = WIDTH'(int'(dd) % int'(dv));
            exp_lat = WIDTH + 1;
        end
        @(negedge Clk);
        Dividend = dd;
        Divisor  = dv;
        Start    = 1'b1;
        edges    = 0;
        busy_cnt = 0;
        do begin
            @(posedge Clk);
            #1;
            edges++;
            if (Busy) busy_cnt++;
            if (scramble && edges == 3) begin
                Dividend = WIDTH'($urandom);
                Divisor  = WIDTH'($urandom);
            end
        end while (!Done && edges < 40);
        chk({tag, " latency"}, edges, exp_lat);
        chk({tag, " busy"}, busy_cnt, (dv == 0) ? 0 : WIDTH);
        chk({tag, " quot"}, Quotient, exp_q);
        chk({tag, " rem"}, Remainder, exp_r);
        chk({tag, " divzero"}, DivZero, (dv == 0) ? 1 : 0);
        if (dv != 0) begin
            chk({tag, " invariant"}, (Quotient * dv + Remainder == dd) && (Remainder < dv), 1);
        end
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge Clk);
                #1;
                if (!Done || Busy || Quotient !== exp_q || Remainder !== exp_r) stable = 1'b0;
            end
            chk({tag, " held"}, stable, 1);
        end
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        #1;
        chk({tag, " idle done"}, Done, 0);
        chk({tag, " idle quot"}, Quotient, exp_q);
        chk({tag, " idle rem"}, Remainder, exp_r);
    endtask

    initial begin
        Reset_n  = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst quot", Quotient, 0);
        chk("rst rem", Remainder, 0);
        chk("rst flags", {Busy, Done, DivZero}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post rst flags", {Busy, Done, DivZero}, 0);

        run_div("d200_7", 8'd200, 8'd7, 1'b0, 0);
        run_div("d255_1", 8'd255, 8'd1, 1'b0, 0);
        run_div("d255_255", 8'd255, 8'd255, 1'b0, 0);
        run_div("d5_10", 8'd5, 8'd10, 1'b0, 0);
        run_div("d100_0", 8'd100, 8'd0, 1'b0, 0);
        run_div("hold", 8'd77, 8'd9, 1'b0, 20);
        run_div("d0_3", 8'd0, 8'd3, 1'b0, 0);
        run_div("scramble", 8'd200, 8'd7, 1'b1, 0);

        // Reset asserted between clock edges in the middle of a computation.
        @(negedge Clk);
        Dividend = 8'd200;
        Divisor  = 8'd7;
        Start    = 1'b1;
        repeat (5) @(posedge Clk);
        #2;
        chk("mid busy", Busy, 1);
        Reset_n = 1'b0;
        #1;
        chk("async quot", Quotient, 0);
        chk("async rem", Remainder, 0);
        chk("async flags", {Busy, Done, DivZero}, 0);
        Start = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        run_div("d13_4", 8'd13, 8'd4, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            run_div($sformatf("rnd%0d", i), a, b, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
